// File: rtl/cmd_exec_ctrl.sv
// Command execution controller. It pops one parsed command at a time, runs a
// single register-bus transaction with an ack/timeout handshake, and streams
// the byte-level response into the TX byte FIFO.
module cmd_exec_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_fifo_empty,
    output logic                       cmd_fifo_rd_en,
    input  logic [8+ADDR_W+DATA_W-1:0] cmd_fifo_rd_data,
    output logic                       reg_req,
    output logic                       reg_we,
    output logic [ADDR_W-1:0]          reg_addr,
    output logic [DATA_W-1:0]          reg_wdata,
    input  logic                       reg_ack,
    input  logic [DATA_W-1:0]          reg_rdata,
    input  logic                       tx_fifo_full,
    output logic                       tx_fifo_wr_en,
    output logic [7:0]                 tx_fifo_wr_data,
    output logic                       busy,
    output logic [7:0]                 err_count
);

    localparam int CMD_W  = 8 + ADDR_W + DATA_W;
    localparam int NBYTES = DATA_W / 8;
    localparam int RESP_N = NBYTES + 1;
    localparam int RESP_W = 8 * RESP_N;
    localparam int IDX_W  = $clog2(RESP_N + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_DATA = 8'h44;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_BUS    = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [7:0]          cmd_op_r;
    logic [ADDR_W-1:0]   cmd_addr_r;
    logic [DATA_W-1:0]   cmd_data_r;
    logic [TO_W-1:0]     to_cnt_r;
    logic [RESP_W-1:0]   resp_buf_r;
    logic [IDX_W-1:0]    resp_idx_r;
    logic [IDX_W-1:0]    resp_last_r;
    logic                op_valid_s;
    logic                timeout_s;
    logic                last_s;

    // Place a one- or two-byte header at the MSB end of the response buffer.
    function automatic logic [RESP_W-1:0] align_hdr(input logic [15:0] hdr);
        logic [RESP_W-1:0] r;
        r = '0;
        r[RESP_W-1 -: 16] = hdr;
        return r;
    endfunction

    // Saturating error counter increment.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    assign op_valid_s = (cmd_op_r == OP_WRITE) || (cmd_op_r == OP_READ);
    assign timeout_s  = (to_cnt_r == TO_LAST);
    assign last_s     = (resp_idx_r == resp_last_r);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ack wins over a simultaneous timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!cmd_fifo_empty) state_s = ST_FETCH;
                else                 state_s = ST_IDLE;
            end
            ST_FETCH:  state_s = ST_DECODE;
            ST_DECODE: begin
                if (op_valid_s) state_s = ST_BUS;
                else            state_s = ST_RESP;
            end
            ST_BUS: begin
                if (reg_ack || timeout_s) state_s = ST_RESP;
                else                      state_s = ST_BUS;
            end
            ST_RESP: begin
                if (!tx_fifo_full && last_s) state_s = ST_IDLE;
                else                         state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: FIFO pop in IDLE, byte push in RESP gated by full.
    always_comb begin
        cmd_fifo_rd_en  = 1'b0;
        tx_fifo_wr_en   = 1'b0;
        tx_fifo_wr_data = 8'h00;
        busy            = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                if (!cmd_fifo_empty && !rst) cmd_fifo_rd_en = 1'b1;
                else                         cmd_fifo_rd_en = 1'b0;
            end
            ST_RESP: begin
                if (!tx_fifo_full) begin
                    tx_fifo_wr_en   = 1'b1;
                    tx_fifo_wr_data = resp_buf_r[RESP_W-1 -: 8];
                end else begin
                    tx_fifo_wr_en   = 1'b0;
                    tx_fifo_wr_data = 8'h00;
                end
            end
            default: busy = 1'b1;
        endcase
    end

    // Datapath: command latch, bus handshake, response buffer, error count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_op_r    <= 8'h00;
            cmd_addr_r  <= '0;
            cmd_data_r  <= '0;
            to_cnt_r    <= '0;
            resp_buf_r  <= '0;
            resp_idx_r  <= '0;
            resp_last_r <= '0;
            reg_req     <= 1'b0;
            reg_we      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            err_count   <= 8'h00;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    cmd_op_r   <= cmd_fifo_rd_data[CMD_W-1 -: 8];
                    cmd_addr_r <= cmd_fifo_rd_data[DATA_W +: ADDR_W];
                    cmd_data_r <= cmd_fifo_rd_data[DATA_W-1:0];
                end
                ST_DECODE: begin
                    if (op_valid_s) begin
                        reg_req   <= 1'b1;
                        reg_we    <= (cmd_op_r == OP_WRITE);
                        reg_addr  <= cmd_addr_r;
                        reg_wdata <= cmd_data_r;
                        to_cnt_r  <= '0;
                    end else begin
                        resp_buf_r  <= align_hdr({RSP_ERR, 8'h01});
                        resp_last_r <= IDX_W'(1);
                        resp_idx_r  <= '0;
                        err_count   <= sat_inc(err_count);
                    end
                end
                ST_BUS: begin
                    if (reg_ack) begin
                        reg_req    <= 1'b0;
                        resp_idx_r <= '0;
                        if (reg_we) begin
                            resp_buf_r  <= align_hdr({RSP_OK, 8'h00});
                            resp_last_r <= '0;
                        end else begin
                            resp_buf_r  <= {RSP_DATA, reg_rdata};
                            resp_last_r <= IDX_W'(NBYTES);
                        end
                    end else if (timeout_s) begin
                        reg_req     <= 1'b0;
                        resp_buf_r  <= align_hdr({RSP_ERR, 8'h02});
                        resp_last_r <= IDX_W'(1);
                        resp_idx_r  <= '0;
                        err_count   <= sat_inc(err_count);
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    if (!tx_fifo_full) begin
                        resp_buf_r <= {resp_buf_r[RESP_W-9:0], 8'h00};
                        resp_idx_r <= resp_idx_r + IDX_W'(1);
                    end else begin
                        resp_idx_r <= resp_idx_r;
                    end
                end
                default: cmd_op_r <= cmd_op_r;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Directed self-checking bench for cmd_exec_ctrl. Inputs are driven at the
// falling edge; outputs are observed 1 ns later, away from the rising edge.
module tb_cmd_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_fifo_empty;
    logic        cmd_fifo_rd_en;
    logic [55:0] cmd_fifo_rd_data;
    logic        reg_req;
    logic        reg_we;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        tx_fifo_full;
    logic        tx_fifo_wr_en;
    logic [7:0]  tx_fifo_wr_data;
    logic        busy;
    logic [7:0]  err_count;

    cmd_exec_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_fifo_empty   (cmd_fifo_empty),
        .cmd_fifo_rd_en   (cmd_fifo_rd_en),
        .cmd_fifo_rd_data (cmd_fifo_rd_data),
        .reg_req          (reg_req),
        .reg_we           (reg_we),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_ack          (reg_ack),
        .reg_rdata        (reg_rdata),
        .tx_fifo_full     (tx_fifo_full),
        .tx_fifo_wr_en    (tx_fifo_wr_en),
        .tx_fifo_wr_data  (tx_fifo_wr_data),
        .busy             (busy),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    // command FIFO model
    logic [55:0] cmd_q[$];
    logic [55:0] pend_data;
    logic        pend_valid = 1'b0;
    int          rd_cycles[$];
    int          rd_while_empty = 0;

    // bus model
    int          ack_delay = 0;
    logic        ack_never = 1'b0;
    logic [31:0] rdata_val = 32'h0;
    int          req_age   = 0;
    logic        prev_req  = 1'b0;
    logic        ack_seen  = 1'b0;
    int          req_total = 0;
    int          req_len_cur = 0;
    int          req_len_last = 0;
    int          req_first_cyc = 0;
    int          req_unstable = 0;
    logic        req_we0;
    logic [15:0] req_addr0;
    logic [31:0] req_wdata0;

    // TX model
    logic [7:0]  tx_q[$];
    logic        bp_en  = 1'b0;
    int          bp_len = 0;
    int          full_cnt = 0;
    int          full_cycles = 0;
    int          wr_while_full = 0;
    int          last_push_cyc = 0;
    int          first_push_cyc = -1;
    logic        prev_busy = 1'b0;
    int          busy_fall_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] mk_cmd(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d);
        return {op, a, d};
    endfunction

    task automatic clear_logs();
        tx_q.delete();
        rd_cycles.delete();
        req_total = 0; req_unstable = 0; req_len_last = 0;
        full_cycles = 0; wr_while_full = 0; first_push_cyc = -1;
        ack_seen = 1'b0; rd_while_empty = 0;
    endtask

    // One clock: drive inputs at negedge, observe outputs 1 ns later.
    task automatic cycle();
        logic ack;
        @(negedge clk);
        cyc++;
        if (pend_valid) begin
            cmd_fifo_rd_data = pend_data;
            pend_valid = 1'b0;
        end
        cmd_fifo_empty = (cmd_q.size() == 0);
        if (reg_req) req_age = prev_req ? req_age + 1 : 0;
        else         req_age = 0;
        ack = reg_req && !ack_never && (req_age == ack_delay);
        reg_ack   = ack;
        reg_rdata = ack ? rdata_val : 32'h0;
        tx_fifo_full = (full_cnt > 0);
        if (full_cnt > 0) full_cnt--;
        if (ack) begin
            ack_seen = 1'b1;
            if (bp_en) full_cnt = bp_len;
        end
        #1;
        if (cmd_fifo_rd_en) begin
            rd_cycles.push_back(cyc);
            if (cmd_fifo_empty) rd_while_empty++;
            else begin
                pend_data = cmd_q.pop_front();
                pend_valid = 1'b1;
            end
        end
        if (reg_req) begin
            req_total++;
            if (!prev_req) begin
                req_first_cyc = cyc; req_len_cur = 1;
                req_we0 = reg_we; req_addr0 = reg_addr; req_wdata0 = reg_wdata;
            end else begin
                req_len_cur++;
                if ({reg_we, reg_addr, reg_wdata} !== {req_we0, req_addr0, req_wdata0}) req_unstable++;
            end
        end else if (prev_req) begin
            req_len_last = req_len_cur;
        end
        if (tx_fifo_wr_en) begin
            if (tx_fifo_full) wr_while_full++;
            tx_q.push_back(tx_fifo_wr_data);
            last_push_cyc = cyc;
            if (first_push_cyc < 0) first_push_cyc = cyc;
        end
        if (tx_fifo_full && busy) full_cycles++;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_req  = reg_req;
        prev_busy = busy;
    endtask

    task automatic wait_idle(input int max_cyc);
        logic done = 1'b0;
        int n = 0;
        while (!done && n < max_cyc) begin
            cycle();
            n++;
            if (cmd_q.size() == 0 && !pend_valid && !busy && !cmd_fifo_rd_en && !reg_req) done = 1'b1;
        end
        check_eq("wait_idle_done", 32'(done), 32'd1);
    endtask

    // Compare the TX log against n expected bytes, MSB first in exp.
    task automatic check_tx(input string tag, input int n, input logic [39:0] exp);
        check_eq({tag, "_count"}, 32'(tx_q.size()), 32'(n));
        for (int i = 0; i < n && i < tx_q.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(tx_q[i]), 32'(exp[39 - 8*i -: 8]));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"},    32'(reg_req),         32'd0);
        check_eq({tag, "_we"},     32'(reg_we),          32'd0);
        check_eq({tag, "_addr"},   32'(reg_addr),        32'd0);
        check_eq({tag, "_wdata"},  reg_wdata,            32'd0);
        check_eq({tag, "_wr_en"},  32'(tx_fifo_wr_en),   32'd0);
        check_eq({tag, "_wr_dat"}, 32'(tx_fifo_wr_data), 32'd0);
        check_eq({tag, "_rd_en"},  32'(cmd_fifo_rd_en),  32'd0);
        check_eq({tag, "_busy"},   32'(busy),            32'd0);
        check_eq({tag, "_err"},    32'(err_count),       32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        reg_ack = 1'b0; tx_fifo_full = 1'b0; full_cnt = 0;
        prev_req = 1'b0; prev_busy = 1'b0; ack_never = 1'b0; bp_en = 1'b0;
        pend_valid = 1'b0; cmd_q.delete();
        cmd_fifo_empty = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cmd_fifo_empty = 1'b1; cmd_fifo_rd_data = 56'h0;
        reg_ack = 1'b0; reg_rdata = 32'h0; tx_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        release_reset();

        // Write with ack two cycles after req.
        clear_logs();
        ack_delay = 2;
        cmd_q.push_back(mk_cmd(8'h57, 16'h0010, 32'hDEADBEEF));
        wait_idle(40);
        check_eq("w_req_len",   32'(req_len_last), 32'd3);
        check_eq("w_req_we",    32'(req_we0),      32'd1);
        check_eq("w_req_addr",  32'(req_addr0),    32'h0010);
        check_eq("w_req_wdata", req_wdata0,        32'hDEADBEEF);
        check_eq("w_req_stable", 32'(req_unstable), 32'd0);
        check_eq("w_req_lat",   32'(req_first_cyc - rd_cycles[0]), 32'd3);
        check_tx("w_tx", 1, 40'h4B00000000);
        check_eq("w_err", 32'(err_count), 32'd0);

        // Read, ack on first BUS cycle; also check first-transaction latency.
        clear_logs();
        ack_delay = 0; rdata_val = 32'h12345678;
        cmd_q.push_back(mk_cmd(8'h52, 16'h0004, 32'h0));
        wait_idle(40);
        check_eq("r_req_we",  32'(req_we0),  32'd0);
        check_eq("r_req_addr", 32'(req_addr0), 32'h0004);
        check_eq("r_req_lat", 32'(req_first_cyc - rd_cycles[0]), 32'd3);
        check_eq("r_push_lat", 32'(first_push_cyc - rd_cycles[0]), 32'd4);
        check_tx("r_tx", 5, 40'h4412345678);
        check_eq("r_busy_fall", 32'(busy_fall_cyc - last_push_cyc), 32'd1);
        check_eq("r_err", 32'(err_count), 32'd0);

        // Bad opcode.
        clear_logs();
        cmd_q.push_back(mk_cmd(8'h99, 16'h0001, 32'h1));
        wait_idle(40);
        check_eq("bad_no_req", 32'(req_total), 32'd0);
        check_tx("bad_tx", 2, 40'h4501000000);
        check_eq("bad_err", 32'(err_count), 32'd1);

        // Read never acked: timeout after 255 cycles of req.
        clear_logs();
        ack_never = 1'b1;
        cmd_q.push_back(mk_cmd(8'h52, 16'h0020, 32'h0));
        wait_idle(400);
        ack_never = 1'b0;
        check_eq("to_req_len", 32'(req_len_last), 32'd255);
        check_tx("to_tx", 2, 40'h4502000000);
        check_eq("to_err", 32'(err_count), 32'd2);

        // Backpressure: TX full for 10 cycles right after the ack.
        clear_logs();
        ack_delay = 0; rdata_val = 32'hAABBCCDD; bp_en = 1'b1; bp_len = 10;
        cmd_q.push_back(mk_cmd(8'h52, 16'h0008, 32'h0));
        wait_idle(60);
        bp_en = 1'b0;
        check_eq("bp_full_seen", 32'(full_cycles), 32'd10);
        check_eq("bp_wr_while_full", 32'(wr_while_full), 32'd0);
        check_tx("bp_tx", 5, 40'h44AABBCCDD);
        check_eq("bp_rd_while_empty", 32'(rd_while_empty), 32'd0);

        // Reset asynchronously in the middle of BUS.
        clear_logs();
        ack_never = 1'b1;
        cmd_q.push_back(mk_cmd(8'h57, 16'h00F0, 32'hCAFEF00D));
        for (int i = 0; i < 20 && !reg_req; i++) cycle();
        check_eq("mbus_req_seen", 32'(reg_req), 32'd1);
        cycle();
        #2 rst = 1'b1;
        #1;
        check_all_zero("mbus_rst");
        release_reset();
        clear_logs();
        repeat (10) cycle();
        check_eq("mbus_idle_tx", 32'(tx_q.size()), 32'd0);
        check_eq("mbus_idle_rd", 32'(rd_cycles.size()), 32'd0);
        check_eq("mbus_idle_busy", 32'(busy), 32'd0);

        // Reset asynchronously while response bytes are being pushed.
        clear_logs();
        ack_delay = 0; rdata_val = 32'h01020304;
        cmd_q.push_back(mk_cmd(8'h52, 16'h0002, 32'h0));
        for (int i = 0; i < 20 && !ack_seen; i++) cycle();
        check_eq("mresp_ack_seen", 32'(ack_seen), 32'd1);
        cycle();
        cycle();
        check_eq("mresp_pushing", 32'(tx_fifo_wr_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("mresp_rst");
        release_reset();
        clear_logs();
        repeat (10) cycle();
        check_eq("mresp_idle_tx", 32'(tx_q.size()), 32'd0);
        check_eq("mresp_idle_busy", 32'(busy), 32'd0);

        // Back-to-back writes, ack immediate.
        clear_logs();
        ack_delay = 0;
        cmd_q.push_back(mk_cmd(8'h57, 16'h0100, 32'h00000001));
        cmd_q.push_back(mk_cmd(8'h57, 16'h0101, 32'h00000002));
        cmd_q.push_back(mk_cmd(8'h57, 16'h0102, 32'h00000003));
        wait_idle(60);
        check_eq("b2b_pops", 32'(rd_cycles.size()), 32'd3);
        if (rd_cycles.size() == 3) begin
            check_eq("b2b_gap1", 32'(rd_cycles[1] - rd_cycles[0]), 32'd5);
            check_eq("b2b_gap2", 32'(rd_cycles[2] - rd_cycles[1]), 32'd5);
        end
        check_tx("b2b_tx", 3, 40'h4B4B4B0000);
        check_eq("b2b_rd_while_empty", 32'(rd_while_empty), 32'd0);
        check_eq("b2b_err", 32'(err_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
